// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared types and constants for the buffered UART transmitter.
//            - tx_state_t : frame sequencer state encoding
//            - EVEN / ODD : values of the par_typ input
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Synchronous first-word-fall-through FIFO feeding the transmitter.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            push/push_data - write request and data (ignored when full)
//            pop/pop_data   - read request (ignored when empty), head word
//            full, empty    - status from the registered occupancy count
//            level          - entries held, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if a pop happens in the same cycle.
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
// ============================================================================
// Module   : uart_tx_buffered
// Purpose  : UART transmitter with an input FIFO. Frames are start bit,
//            DATA_BITS payload bits LSB first, optional parity bit and
//            STOP_BITS stop bits, each bit CLK_FREQ/BAUD_RATE clocks long.
//            Define UART_TX_PARITY_EN to compile in the parity bit; without
//            it par_en/par_typ are ignored and frames never carry parity.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            s_data/s_valid/s_ready - word input handshake
//            par_en, par_typ - parity enable, 0 = even / 1 = odd
//            tx_out          - serial line, idle high, registered
//            busy            - frame in progress or FIFO non-empty
//            fifo_level      - FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buffered #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          par_en,
    input  logic                          par_typ,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import uart_tx_pkg::*;

    localparam int CLK_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int DIV_W     = (CLK_TICKS > 1) ? $clog2(CLK_TICKS) : 1;
    localparam int LW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_TICKS - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_t            state, state_nxt;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 tx_nxt;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [LW-1:0]        level_nxt;

`ifdef UART_TX_PARITY_EN
    logic par_en_r, par_en_nxt;
    logic par_bit_r, par_bit_nxt;
`else
    logic unused_par;
    assign unused_par = par_en ^ par_typ;
`endif

    assign s_ready   = !fifo_full;
    assign push      = s_valid && s_ready;
    assign tick      = (state != IDLE) && (div_cnt == DIV_LAST);
    assign level_nxt = fifo_level + LW'(push) - LW'(pop);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (s_data),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Divider parked at 0 while idle so the start bit gets a full bit time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            tx_out    <= tx_nxt;
            busy      <= (state_nxt != IDLE) || (level_nxt != '0);
`ifdef UART_TX_PARITY_EN
            par_en_r  <= par_en_nxt;
            par_bit_r <= par_bit_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        pop         = 1'b0;
        tx_nxt      = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_en_nxt  = par_en_r;
        par_bit_nxt = par_bit_r;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = START;
                    pop       = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt = shift >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = STOP;
`ifdef UART_TX_PARITY_EN
                        if (par_en_r) state_nxt = PARITY;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        // Chain straight into the next frame when data waits.
                        state_nxt = fifo_empty ? IDLE : START;
                        pop       = !fifo_empty;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Frame setup: word and parity settings are captured at the pop edge.
        if (pop) begin
            shift_nxt   = fifo_dout;
            bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            par_en_nxt  = par_en;
            par_bit_nxt = (^fifo_dout) ^ (par_typ == ODD);
`endif
        end

        // Line level is registered from the next state so it changes on the
        // same edge as the state it belongs to.
        case (state_nxt)
            START:  tx_nxt = 1'b0;
            DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_nxt = par_bit_nxt;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
// Module   : tb_uart_tx_buffered
// Purpose  : Self-checking bench for uart_tx_buffered. Two instances share
//            clock and reset: A (8 data, 1 stop, FIFO depth 4) and
//            B (7 data, 2 stop, FIFO depth 8), both with 10 clocks per bit.
//            Expected frames are queued by the stimulus and checked by a
//            line monitor watching the AND of both serial outputs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_buffered;

    localparam int TICKS = 10;

    typedef struct {
        logic [15:0] bits;   // bit 0 = start bit, LSB-first line order
        int          nbits;
        string       name;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] s_data_a;
    logic       s_valid_a, s_ready_a, par_en_a, par_typ_a, tx_a, busy_a;
    logic [2:0] level_a;
    logic [6:0] s_data_b;
    logic       s_valid_b, s_ready_b, tx_b, busy_b;
    logic       par_en_b = 1'b0;
    logic       par_typ_b = 1'b0;
    logic [3:0] level_b;

    uart_tx_buffered #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .s_data(s_data_a), .s_valid(s_valid_a),
        .s_ready(s_ready_a), .par_en(par_en_a), .par_typ(par_typ_a),
        .tx_out(tx_a), .busy(busy_a), .fifo_level(level_a)
    );

    uart_tx_buffered #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(8)
    ) dut_b (
        .clk(clk), .rst(rst), .s_data(s_data_b), .s_valid(s_valid_b),
        .s_ready(s_ready_b), .par_en(par_en_b), .par_typ(par_typ_b),
        .tx_out(tx_b), .busy(busy_b), .fifo_level(level_b)
    );

    frame_t exp_q[$];
    int     starts[$];
    bit     mon_busy = 1'b0;
    int     n_checks = 0;
    int     n_pass   = 0;
    logic [7:0] burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic frame_t mk(input logic [15:0] b, input int n, input string s);
        frame_t f;
        f.bits = b; f.nbits = n; f.name = s;
        return f;
    endfunction

    // Line monitor: samples every cycle of a frame, so it checks both the
    // bit values and that each bit is stable for exactly TICKS cycles.
    initial begin : monitor
        logic [15:0] act;
        int          nb;
        bit          stable, aborted;
        frame_t      f;
        forever begin
            @(negedge clk);
            if (!rst && (tx_a & tx_b) == 1'b0) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                act = '0; stable = 1'b1; aborted = 1'b0;
                nb = (exp_q.size() > 0) ? exp_q[0].nbits : 10;
                for (int b = 0; b < nb && !aborted; b++) begin
                    for (int c = 0; c < TICKS && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst) aborted = 1'b1;
                        else if (c == 0) act[b] = tx_a & tx_b;
                        else if ((tx_a & tx_b) != act[b]) stable = 1'b0;
                    end
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: got 0x%0h, required no frame", act);
                end else begin
                    f = exp_q.pop_front();
                    if (!aborted) begin
                        chk({f.name, " bits"}, 32'(act), 32'(f.bits));
                        chk({f.name, " bit timing"}, 32'(stable), 1);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic push_a(input logic [7:0] d, input logic [15:0] bits, input int nb, input string name);
        if (nb > 0) exp_q.push_back(mk(bits, nb, name));
        @(negedge clk);
        s_data_a = d; s_valid_a = 1'b1;
        for (int i = 0; i < 500 && !s_ready_a; i++) @(negedge clk);
        if (!s_ready_a) chk({name, " push timeout"}, 0, 1);
        @(negedge clk);
        s_valid_a = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy) break;
        end
        chk({name, " drained"}, 32'(exp_q.size() == 0 && !mon_busy), 1);
        repeat (3) @(negedge clk);
    endtask

    // Exact-latency frame on an idle instance: accept at edge n, start bit
    // from edge n+1, last stop cycle ends at edge n+101.
    task automatic frame_timing(input bit sel_b, input logic [7:0] d, input logic [15:0] bits, input string name);
        exp_q.push_back(mk(bits, 10, name));
        @(negedge clk);
        if (sel_b) begin s_data_b = d[6:0]; s_valid_b = 1'b1; end
        else       begin s_data_a = d;      s_valid_a = 1'b1; end
        @(negedge clk);
        s_valid_a = 1'b0; s_valid_b = 1'b0;
        chk({name, " idle after accept"}, sel_b ? tx_b : tx_a, 1);
        chk({name, " level after accept"}, sel_b ? 32'(level_b) : 32'(level_a), 1);
        @(negedge clk);
        chk({name, " start bit at n+1"}, sel_b ? tx_b : tx_a, 0);
        chk({name, " level after pop"}, sel_b ? 32'(level_b) : 32'(level_a), 0);
        repeat (99) @(negedge clk);
        chk({name, " busy in last stop cycle"}, sel_b ? busy_b : busy_a, 1);
        @(negedge clk);
        chk({name, " busy after frame"}, sel_b ? busy_b : busy_a, 0);
        chk({name, " line idle after frame"}, sel_b ? tx_b : tx_a, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int idx;
        int t0;
        s_data_a = '0; s_valid_a = 1'b0; par_en_a = 1'b0; par_typ_a = 1'b0;
        s_data_b = '0; s_valid_b = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset tx_out", tx_a, 1);
        chk("reset busy", busy_a, 0);
        chk("reset level", 32'(level_a), 0);
        chk("reset s_ready", s_ready_a, 1);
        chk("reset tx_out B", tx_b, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0x55
        frame_timing(1'b0, 8'h55, 16'h02AA, "8N1 0x55");
        wait_drain("8N1");

`ifdef UART_TX_PARITY_EN
        starts.delete();
        par_en_a = 1'b1; par_typ_a = 1'b0;
        push_a(8'h07, 16'h060E, 11, "8E1 0x07");
        repeat (3) @(negedge clk);
        par_typ_a = 1'b1;
        push_a(8'h07, 16'h040E, 11, "8O1 0x07");
        repeat (150) @(negedge clk);
        par_typ_a = 1'b0;
        wait_drain("parity");
        chk("parity frame count", starts.size(), 2);
        if (starts.size() == 2) chk("parity frame length", 32'(starts[1] - starts[0]), 110);
        par_en_a = 1'b0;
`else
        par_en_a = 1'b1; par_typ_a = 1'b0;
        push_a(8'h55, 16'h02AA, 10, "parity ignored 0x55");
        wait_drain("no parity");
        par_en_a = 1'b0;
`endif

        // Burst of 6 into a depth-4 FIFO with s_valid held.
        starts.delete();
        for (int i = 0; i < 6; i++)
            exp_q.push_back(mk(16'h0200 | {7'd0, burst[i], 1'b0}, 10, $sformatf("burst %0d", i)));
        idx = 0;
        @(negedge clk);
        for (int c = 0; c < 400 && idx < 6; c++) begin
            s_data_a = burst[idx]; s_valid_a = 1'b1;
            if (c == 20) begin
                chk("burst accepted before stall", idx, 5);
                chk("burst s_ready low when full", s_ready_a, 0);
                chk("burst level full", 32'(level_a), 4);
            end
            if (s_ready_a) begin
                idx++;
                if (idx == 6) chk("burst 6th accept cycle", c, 102);
            end
            @(negedge clk);
        end
        s_valid_a = 1'b0;
        chk("burst all accepted", idx, 6);
        wait_drain("burst");
        chk("burst frame count", starts.size(), 6);
        for (int i = 0; i + 1 < starts.size(); i++)
            chk($sformatf("burst gap %0d", i), 32'(starts[i+1] - starts[i]), 100);

        // 7 data bits, 2 stop bits on instance B.
        frame_timing(1'b1, 8'h7F, 16'h03FE, "7N2 0x7F");
        wait_drain("7N2");

        // Reset during the 4th data bit, with a second word queued.
        starts.delete();
        push_a(8'hF0, 16'h03E0, 10, "aborted 0xF0");
        push_a(8'h0F, 16'h0000, 0, "flushed 0x0F");
        for (int i = 0; i < 300 && starts.size() == 0; i++) @(negedge clk);
        chk("abort frame started", starts.size(), 1);
        t0 = (starts.size() > 0) ? starts[0] : cyc;
        for (int i = 0; i < 300 && cyc < t0 + 44; i++) @(negedge clk);
        chk("4th data bit low", tx_a, 0);
        #2 rst = 1'b1;
        #1;
        chk("reset tx_out async", tx_a, 1);
        chk("reset level async", 32'(level_a), 0);
        chk("reset busy async", busy_a, 0);
        chk("reset s_ready async", s_ready_a, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        push_a(8'hA3, 16'h0346, 10, "after reset 0xA3");
        wait_drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
